// File: rtl/compare_scheduler_pkg.sv
// rtl/compare_scheduler_pkg.sv - shared constants and width helper for the compare scheduler
package compare_scheduler_pkg;

   localparam int NIB_BITS = 4;

   // Index width that never collapses to zero bits for single-entry ranges.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/compare_scheduler_if.sv
// rtl/compare_scheduler_if.sv - requester-side bundle of the compare scheduler
interface compare_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16
);
   logic [N_REQ-1:0]                                 req;
   logic [N_REQ*WIDTH-1:0]                           a_flat;
   logic [N_REQ*WIDTH-1:0]                           b_flat;
   logic [N_REQ-1:0]                                 gnt;
   logic                                             busy;
   logic                                             done;
   logic [compare_scheduler_pkg::idx_w(N_REQ)-1:0]   done_id;
   logic                                             equal;

   modport master (output req, a_flat, b_flat, input gnt, busy, done, done_id, equal);
   modport slave  (input req, a_flat, b_flat, output gnt, busy, done, done_id, equal);
endinterface

// File: rtl/compare_sched_defs.vh
// rtl/compare_sched_defs.vh - state encodings and derived widths, included inside the scheduler body
localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_CMP  = 2'd1;
localparam logic [1:0] ST_DONE = 2'd2;
localparam int NIB = WIDTH / NIB_BITS;
localparam int KW  = idx_w(NIB);
localparam int IDW = idx_w(N_REQ);

// File: rtl/compare_scheduler_eq4.sv
// rtl/compare_scheduler_eq4.sv - shared 4-bit equality comparator
module EqualityComparator4Bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic       eq_o
);
   assign eq_o = (a_i == b_i);
endmodule

// File: rtl/compare_scheduler.sv
// rtl/compare_scheduler.sv - round-robin wide equality checks over one shared 4-bit comparator
module compare_scheduler
   import compare_scheduler_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16
) (
   input logic               clk,
   input logic               rst_n,
   compare_scheduler_if.slave bus
);
   `include "compare_sched_defs.vh"

   typedef enum logic [1:0] {IDLE = ST_IDLE, CMP = ST_CMP, DONE = ST_DONE} state_t;

   state_t             state_q, state_d;
   logic [KW-1:0]      k_q, k_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [IDW-1:0]     win_q, win_d, rr_ptr_q, rr_ptr_d, pick_idx;
   logic               eqn_q, eqn_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               busy_q, done_q, equal_q;
   logic [IDW-1:0]     done_id_q;
   logic [3:0]         cmp_a, cmp_b;
   logic               cmp_eq;

   assign cmp_a = a_q[k_q*NIB_BITS +: NIB_BITS];
   assign cmp_b = b_q[k_q*NIB_BITS +: NIB_BITS];

   EqualityComparator4Bit u_eq (.a_i(cmp_a), .b_i(cmp_b), .eq_o(cmp_eq));

   // Scan from the highest offset down so the closest requester to rr_ptr wins.
   always_comb begin
      pick_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (bus.req[(int'(rr_ptr_q) + i) % N_REQ]) pick_idx = IDW'((int'(rr_ptr_q) + i) % N_REQ);
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      a_d      = a_q;
      b_d      = b_q;
      win_d    = win_q;
      rr_ptr_d = rr_ptr_q;
      eqn_d    = eqn_q;
      gnt_d    = '0;
      unique case (state_q)
         IDLE: begin
            if (|bus.req) begin
               gnt_d[pick_idx] = 1'b1;
               a_d     = bus.a_flat[int'(pick_idx)*WIDTH +: WIDTH];
               b_d     = bus.b_flat[int'(pick_idx)*WIDTH +: WIDTH];
               win_d   = pick_idx;
               k_d     = '0;
               state_d = CMP;
            end
         end
         CMP: begin
            if (!cmp_eq) begin
               eqn_d   = 1'b0;
               state_d = DONE;
            end else if (k_q == KW'(NIB - 1)) begin
               eqn_d   = 1'b1;
               state_d = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            rr_ptr_d = (int'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered views of the FSM, so done trails the DONE state by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         win_q     <= '0;
         rr_ptr_q  <= '0;
         eqn_q     <= 1'b0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         equal_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         a_q      <= a_d;
         b_q      <= b_d;
         win_q    <= win_d;
         rr_ptr_q <= rr_ptr_d;
         eqn_q    <= eqn_d;
         gnt_q    <= gnt_d;
         busy_q   <= (state_q != IDLE);
         done_q   <= (state_q == DONE);
         if (state_q == DONE) begin
            done_id_q <= win_q;
            equal_q   <= eqn_q;
         end
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.equal   = equal_q;

endmodule

// File: tb/tb_compare_scheduler.sv
// tb/tb_compare_scheduler.sv - directed self-checking bench for compare_scheduler
module tb_compare_scheduler;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   compare_scheduler_if #(.N_REQ(4), .WIDTH(16)) bus ();
   compare_scheduler #(.N_REQ(4), .WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_gnt(output logic [3:0] g);
      int n;
      n = 0;
      g = '0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (bus.gnt != 4'b0) begin
            g = bus.gnt;
            break;
         end
      end
      if (g == 4'b0) chk("gnt_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(output int lat, output bit b2b);
      lat = 0;
      b2b = 1'b0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (bus.gnt != 4'b0) b2b = 1'b1;
         if (bus.done) break;
      end
   endtask

   task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b);
      bus.a_flat[id*16 +: 16] = a;
      bus.b_flat[id*16 +: 16] = b;
   endtask

   task automatic run_one(input string tag, input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] a_after, input bit exp_eq, input int exp_lat);
      logic [3:0] g;
      int lat;
      bit b2b;
      set_ops(id, a, b);
      bus.req[id] = 1'b1;
      wait_gnt(g);
      bus.req[id] = 1'b0;
      bus.a_flat[id*16 +: 16] = a_after;
      chk({tag, "_gnt"}, 32'(g), 32'(4'b0001 << id));
      chk({tag, "_busy_at_gnt"}, 32'(bus.busy), 32'd0);
      wait_done(lat, b2b);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_equal"}, 32'(bus.equal), 32'(exp_eq));
      chk({tag, "_id"}, 32'(bus.done_id), 32'(id));
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, "_equal_hold"}, 32'(bus.equal), 32'(exp_eq));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] g;
      int lat;
      bit b2b;
      int seen_done;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.req = '0;
      bus.a_flat = '0;
      bus.b_flat = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_id", 32'(bus.done_id), 32'd0);
      chk("rst_equal", 32'(bus.equal), 32'd0);

      run_one("full_match", 0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b1, 5);
      run_one("early_mis", 2, 16'h00F0, 16'h00F1, 16'h00F0, 1'b0, 2);

      // Abort mid-comparison: rr_ptr is 3 here, so a surviving pointer would favour requester 3.
      set_ops(0, 16'h1234, 16'h1234);
      bus.req[0] = 1'b1;
      wait_gnt(g);
      bus.req[0] = 1'b0;
      chk("abort_gnt", 32'(g), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_gnt_0", 32'(bus.gnt), 32'd0);
      chk("abort_busy_0", 32'(bus.busy), 32'd0);
      chk("abort_done_0", 32'(bus.done), 32'd0);
      chk("abort_id_0", 32'(bus.done_id), 32'd0);
      chk("abort_equal_0", 32'(bus.equal), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) seen_done++;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);
      set_ops(3, 16'h7777, 16'h7777);
      bus.req = 4'b1001;
      wait_gnt(g);
      bus.req = 4'b0000;
      chk("abort_next_gnt", 32'(g), 32'd1);
      wait_done(lat, b2b);
      chk("abort_next_lat", 32'(lat), 32'd5);

      run_one("last_mis", 1, 16'h1234, 16'h2234, 16'h1234, 1'b0, 5);
      run_one("op_change", 1, 16'hAAAA, 16'hAAAA, 16'h5555, 1'b1, 5);

      do_reset();
      for (int i = 0; i < 4; i++) set_ops(i, 16'(i * 16'h1111), 16'(i * 16'h1111));
      bus.req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_gnt(g);
         chk($sformatf("rr_gnt%0d", n), 32'(g), 32'(4'b0001 << (n % 4)));
         wait_done(lat, b2b);
         chk($sformatf("rr_id%0d", n), 32'(bus.done_id), 32'(n % 4));
         chk($sformatf("rr_b2b%0d", n), 32'(b2b), 32'd0);
         chk($sformatf("rr_eq%0d", n), 32'(bus.equal), 32'd1);
      end
      bus.req = '0;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
